watch_date: RTL

Calendar stage directly downstream of the time-of-day counter. Consumes its one-cycle end-of-day pulse and maintains year (2000–2099), month, day and weekday with Gregorian month lengths and leap years. Supports a binary date load and derives the weekday of a loaded date with a short iterative computation. Feeds the display/format stage alongside the time-of-day outputs.

---
 rtl/watch_pkg.sv | 62 ++++++
 rtl/watch_date_if.sv | 19 +
 rtl/date_wday_calc.sv | 96 +++++++++
 rtl/watch_date.sv | 115 +++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared calendar definitions for the watch datapath: field layout, month and
// weekday encodings, and Gregorian helpers valid for 2000-2099.
package watch_pkg;

   localparam int unsigned YEAR_W    = 7;
   localparam int unsigned MONTH_W   = 4;
   localparam int unsigned DAY_W     = 5;
   localparam int unsigned WDAY_W    = 3;
   localparam int unsigned DATE_W    = YEAR_W + MONTH_W + DAY_W;
   localparam int unsigned DAY_LSB   = 0;
   localparam int unsigned MONTH_LSB = DAY_LSB + DAY_W;
   localparam int unsigned YEAR_LSB  = MONTH_LSB + MONTH_W;
   localparam int unsigned YEAR_MAX  = 99;

   typedef enum logic [MONTH_W-1:0] {
      JAN = 4'd1, FEB = 4'd2, MAR = 4'd3, APR = 4'd4, MAY = 4'd5,  JUN = 4'd6,
      JUL = 4'd7, AUG = 4'd8, SEP = 4'd9, OCT = 4'd10, NOV = 4'd11, DEC = 4'd12
   } month_e;

   typedef enum logic [WDAY_W-1:0] {
      SUN = 3'd0, MON = 3'd1, TUE = 3'd2, WED = 3'd3, THU = 3'd4, FRI = 3'd5, SAT = 3'd6
   } wday_e;

   localparam logic [WDAY_W-1:0] EPOCH_WDAY_DEF = WDAY_W'(SAT);

   typedef struct packed {
      logic [YEAR_W-1:0]  year;
      logic [MONTH_W-1:0] month;
      logic [DAY_W-1:0]   day;
   } date_t;

   typedef enum logic [1:0] {ST_IDLE, ST_YEARS, ST_MONTHS, ST_DAYS} calc_state_e;

   // Every fourth year is leap; exact because 2000 is leap and 2100 is out of range.
   function automatic logic is_leap(input logic [YEAR_W-1:0] year);
      return (year[1:0] == 2'b00);
   endfunction

   function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                      input logic [YEAR_W-1:0]  year);
      logic [DAY_W-1:0] dim;
      dim = 5'd31;
      if (month == MONTH_W'(FEB))
         dim = is_leap(year) ? 5'd29 : 5'd28;
      else if (month == MONTH_W'(APR) || month == MONTH_W'(JUN) ||
               month == MONTH_W'(SEP) || month == MONTH_W'(NOV))
         dim = 5'd30;
      return dim;
   endfunction

   function automatic logic [WDAY_W-1:0] mod7_add(input logic [WDAY_W-1:0] a,
                                                  input logic [WDAY_W-1:0] b);
      logic [WDAY_W:0] s;
      s = (WDAY_W+1)'(a) + (WDAY_W+1)'(b);
      return (s >= 4'd7) ? WDAY_W'(s - 4'd7) : WDAY_W'(s);
   endfunction

   function automatic logic [WDAY_W-1:0] wday_next(input logic [WDAY_W-1:0] w);
      return (w == WDAY_W'(SAT)) ? WDAY_W'(SUN) : w + 3'd1;
   endfunction

endpackage

// File: rtl/watch_date_if.sv
// Date-stage bus: control/load inputs from the time counter side, calendar outputs back.
interface watch_date_if;
   import watch_pkg::*;

   logic                en_day;
   logic                set_date;
   logic [DATE_W-1:0]   bin_date;
   logic [YEAR_W-1:0]   year;
   logic [MONTH_W-1:0]  month;
   logic [DAY_W-1:0]    day;
   logic [WDAY_W-1:0]   wday;
   logic                busy;
   logic                en_year;

   modport master (output en_day, set_date, bin_date,
                   input  year, month, day, wday, busy, en_year);
   modport slave  (input  en_day, set_date, bin_date,
                   output year, month, day, wday, busy, en_year);
endinterface

// File: rtl/date_wday_calc.sv
// Iterative weekday derivation for a loaded date (year steps, then month steps),
// plus the running weekday register that follows day advances.
module date_wday_calc
   import watch_pkg::*;
#(
   parameter logic [WDAY_W-1:0] EPOCH_WDAY = EPOCH_WDAY_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                adv,
   input  logic [YEAR_W-1:0]   year,
   input  logic [MONTH_W-1:0]  month,
   input  logic [DAY_W-1:0]    day,
   output logic                busy,
   output logic [WDAY_W-1:0]   wday
);

   calc_state_e         state_q, state_d;
   logic [YEAR_W-1:0]   idx_q, idx_d;
   logic [WDAY_W-1:0]   acc_q, acc_d;
   logic                busy_q, busy_d;
   logic [WDAY_W-1:0]   wday_q, wday_d;

   function automatic logic [WDAY_W-1:0] final_wday(input logic [WDAY_W-1:0] acc,
                                                    input logic [DAY_W-1:0]  d);
      logic [5:0] t;
      t = 6'(acc) + 6'(d) - 6'd1;
      return WDAY_W'(t % 6'd7);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         acc_q   <= EPOCH_WDAY;
         busy_q  <= 1'b0;
         wday_q  <= EPOCH_WDAY;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         busy_q  <= busy_d;
         wday_q  <= wday_d;
      end
   end

   // The result is registered on leaving MONTHS so busy drops as DAYS begins;
   // DAYS is then the first idle cycle, where a held-back advance may land.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      busy_d  = busy_q;
      wday_d  = wday_q;
      case (state_q)
         ST_IDLE: begin
            if (adv) wday_d = wday_next(wday_q);
         end
         ST_YEARS: begin
            if (idx_q < year) begin
               acc_d = mod7_add(acc_q, is_leap(idx_q) ? 3'd2 : 3'd1);
               idx_d = idx_q + 7'd1;
            end else begin
               idx_d   = 7'd1;
               state_d = ST_MONTHS;
            end
         end
         ST_MONTHS: begin
            if (idx_q < YEAR_W'(month)) begin
               acc_d = mod7_add(acc_q, WDAY_W'(days_in_month(idx_q[MONTH_W-1:0], year) - 5'd28));
               idx_d = idx_q + 7'd1;
            end else begin
               wday_d  = final_wday(acc_q, day);
               busy_d  = 1'b0;
               state_d = ST_DAYS;
            end
         end
         ST_DAYS: begin
            state_d = ST_IDLE;
            if (adv) wday_d = wday_next(wday_q);
         end
         default: state_d = ST_IDLE;
      endcase
      if (start) begin
         state_d = ST_YEARS;
         idx_d   = '0;
         acc_d   = EPOCH_WDAY;
         busy_d  = 1'b1;
      end
   end

   assign busy = busy_q;
   assign wday = wday_q;

endmodule

// File: rtl/watch_date.sv
// Calendar stage: date registers, load sanitiser, end-of-day advance with
// year rollover, and one-deep deferral of advances during weekday computation.
module watch_date
   import watch_pkg::*;
#(
   parameter int unsigned       YEAR_BASE  = 2000,
   parameter logic [WDAY_W-1:0] EPOCH_WDAY = EPOCH_WDAY_DEF
) (
   input  logic         clk,
   input  logic         rst,
   watch_date_if.slave  bus
);

   // The two-bit leap rule needs a leap-aligned century base.
   if (YEAR_BASE % 4 != 0) begin : g_base_chk
      $error("watch_date: YEAR_BASE must be a multiple of 4");
   end

   date_t               date_q;
   date_t               load_c;
   date_t               next_c;
   logic [DAY_W-1:0]    load_dim_c;
   logic [DAY_W-1:0]    cur_dim_c;
   logic                roll_c;
   logic                adv_c;
   logic                pending_q;
   logic                en_year_q;
   logic                busy;
   logic [WDAY_W-1:0]   wday;
   logic [YEAR_W-1:0]   raw_year;
   logic [MONTH_W-1:0]  raw_month;
   logic [DAY_W-1:0]    raw_day;

   assign raw_year  = bus.bin_date[YEAR_LSB  +: YEAR_W];
   assign raw_month = bus.bin_date[MONTH_LSB +: MONTH_W];
   assign raw_day   = bus.bin_date[DAY_LSB   +: DAY_W];

   // Clamp a requested date into a legal calendar date.
   always_comb begin
      load_c.year  = (raw_year > YEAR_W'(YEAR_MAX)) ? YEAR_W'(YEAR_MAX) : raw_year;
      load_c.month = (raw_month == '0 || raw_month > MONTH_W'(DEC)) ? MONTH_W'(JAN) : raw_month;
      load_dim_c   = days_in_month(load_c.month, load_c.year);
      if (raw_day == '0)
         load_c.day = 5'd1;
      else if (raw_day > load_dim_c)
         load_c.day = load_dim_c;
      else
         load_c.day = raw_day;
   end

   // Next-day date.
   always_comb begin
      next_c    = date_q;
      roll_c    = 1'b0;
      cur_dim_c = days_in_month(date_q.month, date_q.year);
      if (date_q.day < cur_dim_c) begin
         next_c.day = date_q.day + 5'd1;
      end else begin
         next_c.day = 5'd1;
         if (date_q.month == MONTH_W'(DEC)) begin
            next_c.month = MONTH_W'(JAN);
            next_c.year  = (date_q.year == YEAR_W'(YEAR_MAX)) ? '0 : date_q.year + 7'd1;
            roll_c       = 1'b1;
         end else begin
            next_c.month = date_q.month + 4'd1;
         end
      end
   end

   assign adv_c = !bus.set_date && !busy && (bus.en_day || pending_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         date_q.year  <= '0;
         date_q.month <= MONTH_W'(JAN);
         date_q.day   <= 5'd1;
         pending_q    <= 1'b0;
         en_year_q    <= 1'b0;
      end else begin
         en_year_q <= 1'b0;
         if (bus.set_date) begin
            date_q    <= load_c;
            pending_q <= 1'b0;
         end else if (busy) begin
            if (bus.en_day) pending_q <= 1'b1;
         end else if (adv_c) begin
            date_q    <= next_c;
            pending_q <= 1'b0;
            en_year_q <= roll_c;
         end
      end
   end

   date_wday_calc #(
      .EPOCH_WDAY (EPOCH_WDAY)
   ) u_calc (
      .clk   (clk),
      .rst   (rst),
      .start (bus.set_date),
      .adv   (adv_c),
      .year  (date_q.year),
      .month (date_q.month),
      .day   (date_q.day),
      .busy  (busy),
      .wday  (wday)
   );

   assign bus.year    = date_q.year;
   assign bus.month   = date_q.month;
   assign bus.day     = date_q.day;
   assign bus.wday    = wday;
   assign bus.busy    = busy;
   assign bus.en_year = en_year_q;

endmodule
